// File: rtl/eager_fork_pkg.sv
// eager_fork_pkg: width helper shared by the eager fork files.
package eager_fork_pkg;

    // A dataless token still needs a one-bit vector to keep port ranges legal.
    function automatic int safe_w(input int w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/eager_fork_register_block.sv
// eager_fork_register_block: pending flag for one fork output and its stall term.
module eager_fork_register_block (
    input  logic clk,
    input  logic rst,
    input  logic ins_valid,
    input  logic outs_ready,
    input  logic any_stop,
    output logic outs_valid,
    output logic stop
);

    logic pending_q;
    logic pending_d;

    always_comb begin
        outs_valid = ins_valid & pending_q;
        stop       = outs_valid & ~outs_ready;
        pending_d  = stop | ~any_stop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= 1'b1;
        else     pending_q <= pending_d;
    end

endmodule

// File: rtl/eager_fork.sv
// eager_fork: replicates one valid/ready token to SIZE consumers, each taking it
// independently; the input is released once every output has taken it.
module eager_fork
    import eager_fork_pkg::*;
#(
    parameter int SIZE      = 2,
    parameter int DATA_TYPE = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [safe_w(DATA_TYPE)-1:0]       ins,
    input  logic                               ins_valid,
    output logic                               ins_ready,
    output logic [SIZE*safe_w(DATA_TYPE)-1:0]  outs,
    output logic [SIZE-1:0]                    outs_valid,
    input  logic [SIZE-1:0]                    outs_ready
);

    logic [SIZE-1:0] stop;
    logic            any_stop;

    for (genvar i = 0; i < SIZE; i++) begin : g_rb
        eager_fork_register_block u_rb (
            .clk        (clk),
            .rst        (rst),
            .ins_valid  (ins_valid),
            .outs_ready (outs_ready[i]),
            .any_stop   (any_stop),
            .outs_valid (outs_valid[i]),
            .stop       (stop[i])
        );
    end

    assign any_stop  = |stop;
    assign ins_ready = ~any_stop;
    assign outs      = {SIZE{ins}};

endmodule

// File: tb/tb_eager_fork.sv
// tb_eager_fork: directed and scoreboarded checks of eager_fork in three configurations.
module tb_eager_fork;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] a_ins;
    logic        a_iv, a_ir;
    logic [63:0] a_outs;
    logic [1:0]  a_ov, a_or;

    logic [31:0] b_ins;
    logic        b_iv, b_ir;
    logic [95:0] b_outs;
    logic [2:0]  b_ov, b_or;

    logic [0:0]  c_ins, c_outs;
    logic        c_iv, c_ir;
    logic [0:0]  c_ov, c_or;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    eager_fork #(.SIZE(2), .DATA_TYPE(32)) u_a (
        .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_iv), .ins_ready(a_ir),
        .outs(a_outs), .outs_valid(a_ov), .outs_ready(a_or)
    );

    eager_fork #(.SIZE(3), .DATA_TYPE(32)) u_b (
        .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_iv), .ins_ready(b_ir),
        .outs(b_outs), .outs_valid(b_ov), .outs_ready(b_or)
    );

    eager_fork #(.SIZE(1), .DATA_TYPE(0)) u_c (
        .clk(clk), .rst(rst), .ins(c_ins), .ins_valid(c_iv), .ins_ready(c_ir),
        .outs(c_outs), .outs_valid(c_ov), .outs_ready(c_or)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] served, acc, ov_exp;
        int         exp_cnt[3];
        int         t, cycles;
        void'($urandom(42));
        rst = 1'b1;
        a_ins = 32'hA5; a_iv = 1'b0; a_or = 2'b11;
        b_ins = '0;     b_iv = 1'b0; b_or = '0;
        c_ins = '0;     c_iv = 1'b0; c_or = '0;
        #1;
        chk("rst_ov_idle", a_ov, 2'b00);
        chk("rst_ir_idle", a_ir, 1);
        a_iv = 1'b1;
        #1;
        chk("rst_ov_valid", a_ov, 2'b11);
        #1 rst = 1'b0;
        #1;
        // test 1: both ready at release
        chk("t1_ov", a_ov, 2'b11);
        chk("t1_ir", a_ir, 1);
        chk("t1_d0", a_outs[31:0], 32'hA5);
        chk("t1_d1", a_outs[63:32], 32'hA5);
        cyc();
        // test 2: out0 first, out1 three cycles later
        a_ins = 32'hB6; a_or = 2'b01;
        #1;
        chk("t2_c0_ov", a_ov, 2'b11);
        chk("t2_c0_ir", a_ir, 0);
        cyc();
        chk("t2_c1_ov", a_ov, 2'b10);
        chk("t2_c1_ir", a_ir, 0);
        cyc();
        chk("t2_c2_ov", a_ov, 2'b10);
        chk("t2_c2_ir", a_ir, 0);
        cyc();
        a_or = 2'b10;
        #1;
        chk("t2_c3_ov", a_ov, 2'b10);
        chk("t2_c3_ir", a_ir, 1);
        chk("t2_c3_d1", a_outs[63:32], 32'hB6);
        cyc();
        a_ins = 32'hC7; a_or = 2'b00;
        #1;
        chk("t2_reload_ov", a_ov, 2'b11);
        chk("t2_reload_ir", a_ir, 0);
        // test 5: reset mid-token
        a_or = 2'b01;
        cyc();
        a_or = 2'b00;
        #1;
        chk("t5_pre_ov", a_ov, 2'b10);
        rst = 1'b1;
        #1;
        chk("t5_async_ov", a_ov, 2'b11);
        rst = 1'b0;
        #1;
        chk("t5_post_ov", a_ov, 2'b11);
        chk("t5_post_d0", a_outs[31:0], 32'hC7);
        cyc();
        chk("t5_hold_ov", a_ov, 2'b11);
        a_or = 2'b11;
        #1;
        chk("t5_done_ir", a_ir, 1);
        cyc();
        // test 3: back-to-back tokens
        for (int k = 1; k <= 3; k++) begin
            a_ins = k;
            #1;
            chk("t3_ov", a_ov, 2'b11);
            chk("t3_ir", a_ir, 1);
            chk("t3_d", a_outs, {32'(k), 32'(k)});
            cyc();
        end
        a_iv = 1'b0;
        #1;
        chk("t3_idle_ov", a_ov, 2'b00);
        // test 4: random ready, per-output scoreboard
        served = '0; t = 0; cycles = 0;
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
        b_iv = 1'b1;
        while (t < 1000 && cycles < 20000) begin
            b_ins = t;
            b_or  = 3'($urandom_range(0, 7));
            #1;
            ov_exp = ~served;
            chk("t4_ov", b_ov, ov_exp);
            acc = b_ov & b_or;
            chk("t4_ir", b_ir, (served | acc) == 3'b111);
            for (int i = 0; i < 3; i++)
                if (acc[i]) begin
                    chk("t4_data", b_outs[i*32 +: 32], exp_cnt[i]);
                    exp_cnt[i]++;
                end
            served = ((served | acc) == 3'b111) ? 3'b000 : (served | acc);
            if (b_ir) t++;
            cyc();
            cycles++;
        end
        chk("t4_tokens", t, 1000);
        for (int i = 0; i < 3; i++) chk("t4_count", exp_cnt[i], 1000);
        b_iv = 1'b0;
        // test 6: SIZE=1 dataless wire behaviour
        for (int k = 0; k < 4; k++) begin
            c_iv = k[1];
            c_or = k[0];
            #1;
            chk("t6_ov", c_ov, c_iv);
            chk("t6_ir", c_ir, c_iv ? c_or : 1'b1);
            cyc();
        end
        c_iv = 1'b1; c_or = 1'b0;
        cyc();
        cyc();
        chk("t6_hold_ov", c_ov, 1);
        chk("t6_hold_ir", c_ir, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
